// File: rtl/digit_addsub.sv
// digit_addsub: multi-cycle WIDTH-bit adder/subtractor. Each RUN cycle it
// handles DIGIT bits, LSB first, so the carry chain is only DIGIT bits long.
// Flags are the same as the single-cycle add/sub units: carry, signed
// overflow and zero.
module digit_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             o,
  output logic             z,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  // Reject illegal geometry at elaboration.
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("digit_addsub: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] xr, yr, part;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] part_nxt;
  logic             last;
  logic             accept;

  // One digit add. The low bits of the operand shift registers always hold
  // the digit that is being worked on.
  assign dsum = {1'b0, xr[DIGIT-1:0]} + {1'b0, yr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

  // The new digit enters the partial sum from the top. After N shifts the
  // whole result is aligned. A wide shift also covers DIGIT == WIDTH.
  assign part_nxt = WIDTH'({dsum[DIGIT-1:0], part} >> DIGIT);

  assign last   = (cnt == CW'(N - 1));
  assign accept = (state == IDLE) && in_valid;

  // The handshake outputs come only from the registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, carry, counter, partial sum and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr    <= '0;
      yr    <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c     <= 1'b0;
      o     <= 1'b0;
      z     <= 1'b0;
    end else if (accept) begin
      xr    <= x;
      yr    <= y ^ {WIDTH{sub}};
      part  <= '0;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      xr    <= xr >> DIGIT;
      yr    <= yr >> DIGIT;
      part  <= part_nxt;
      carry <= dsum[DIGIT];
      cnt   <= cnt + 1'b1;
      if (last) begin
        // On the last digit, xr/yr hold the MSB digit. That gives the
        // sign bits needed for the overflow flag.
        s <= part_nxt;
        c <= dsum[DIGIT];
        o <= (xr[DIGIT-1] == yr[DIGIT-1]) && (dsum[DIGIT-1] != xr[DIGIT-1]);
        z <= ~|part_nxt;
      end
    end
  end

endmodule

// File: tb/tb_digit_addsub.sv
// Bench for digit_addsub: WIDTH=8 with DIGIT = 1, 2, 4 and 8 (instances 0..3).
// Directed cases run on DIGIT=2, followed by random sweeps on all four
// instances.
module tb_digit_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x, y;
  logic       sub;
  logic       in_valid [4];
  logic       out_ready[4];
  logic       in_ready [4];
  logic       out_valid[4];
  logic       busy     [4];
  logic       c [4];
  logic       o [4];
  logic       z [4];
  logic [7:0] s [4];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_addsub #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .x(x), .y(y), .sub(sub),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .s(s[g]), .c(c[g]), .o(o[g]), .z(z[g]), .busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model in plain integer arithmetic: the unsigned result
  // determines the carry/borrow, and the signed result range determines
  // overflow.
  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic sb,
                                 output logic [7:0] rs, output logic rc, output logic ro,
                                 output logic rz);
    int ua, ub, sa, sbv, r, sr;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    if (!sb) begin r = ua + ub; sr = sa + sbv; rc = (r > 255); end
    else     begin r = ua - ub; sr = sa - sbv; rc = (ua >= ub); end
    rs = r[7:0];
    ro = (sr > 127) || (sr < -128);
    rz = (rs == 8'h00);
  endfunction

  // Run one operation on instance k. The task checks the latency, returns the
  // result and completes the output handshake.
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic sb,
                        output logic [7:0] rs, output logic rc, output logic ro, output logic rz);
    int lat;
    @(negedge clk);
    chk("in_ready_before_op", in_ready[k], 1);
    x = a; y = b; sub = sb; in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    x = 8'($urandom); y = 8'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 8 >> k);
    rs = s[k]; rc = c[k]; ro = o[k]; rz = z[k];
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    chk("in_ready_after_hs", in_ready[k], 1);
  endtask

  task automatic dir_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sb,
                        input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    logic [7:0] rs;
    logic rc, ro, rz;
    run_op(1, a, b, sb, rs, rc, ro, rz);
    chk({tag, ".s"}, rs, es);
    chk({tag, ".c"}, rc, ec);
    chk({tag, ".o"}, ro, eo);
    chk({tag, ".z"}, rz, ez);
  endtask

  initial begin
    logic [7:0] a, b, rs, es;
    logic sb, rc, ro, rz, ec, eo, ez;
    int lat;
    rst = 1'b1; x = '0; y = '0; sub = 1'b0;
    for (int i = 0; i < 4; i++) begin in_valid[i] = 1'b0; out_ready[i] = 1'b0; end
    #12;
    chk("rst.in_ready", in_ready[1], 1);
    chk("rst.out_valid", out_valid[1], 0);
    chk("rst.busy", busy[1], 0);
    chk("rst.s", s[1], 0);
    @(negedge clk);
    rst = 1'b0;

    dir_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    dir_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    dir_op("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    dir_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    dir_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Backpressure: hold the result and check that new requests are ignored.
    @(negedge clk);
    x = 8'h11; y = 8'h22; sub = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp.latency", lat, 4);
    for (int i = 0; i < 3; i++) begin
      x = 8'($urandom); y = 8'($urandom); in_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.out_valid", out_valid[1], 1);
      chk("bp.in_ready", in_ready[1], 0);
      chk("bp.s", s[1], 8'h33);
      chk("bp.flags", {c[1], o[1], z[1]}, 3'b000);
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[1] = 1'b0;
    chk("bp.release_out_valid", out_valid[1], 0);
    chk("bp.release_in_ready", in_ready[1], 1);
    dir_op("bp_fresh", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

    // Assert async reset partway through the second RUN cycle.
    @(negedge clk);
    x = 8'h55; y = 8'h11; sub = 1'b0; in_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", out_valid[1], 0);
    chk("arst.busy", busy[1], 0);
    chk("arst.in_ready", in_ready[1], 1);
    chk("arst.s", s[1], 0);
    chk("arst.flags", {c[1], o[1], z[1]}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    dir_op("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    // Random sweep over all DIGIT values.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 1000; n++) begin
        a = 8'($urandom); b = 8'($urandom); sb = 1'($urandom);
        if (n % 16 == 0) b = a;
        ref_op(a, b, sb, es, ec, eo, ez);
        run_op(k, a, b, sb, rs, rc, ro, rz);
        chk("rnd.s", rs, es);
        chk("rnd.c", rc, ec);
        chk("rnd.o", ro, eo);
        chk("rnd.z", rz, ez);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/digit_addsub.md
# digit_addsub

Parametrised multi-cycle N-bit adder/subtractor with carry, signed-overflow and zero flags. It processes DIGIT bits per cycle from LSB to MSB, trading latency for a short carry chain. It sits in the execute path as a valid/ready slave on the operand side and a valid/ready master on the result side. Flag semantics match the team's single-cycle add/sub units, so it can replace them directly.

## Interface
- WIDTH, 32, operand/result width; ≥1
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH, WIDTH % DIGIT == 0 (elaboration error otherwise)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands (high only in IDLE)
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- sub  in  1  0 = x+y, 1 = x−y
- out_valid  out  1  result registers hold a new result
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference
- c  out  1  carry out of MSB (for sub: 1 = no borrow, x ≥ y unsigned)
- o  out  1  signed overflow
- z  out  1  s == 0
- busy  out  1  high in RUN or DONE

## Operation
- Arithmetic: ye = y XOR {WIDTH{sub}}, cin = sub; {c,s} = x + ye + cin (WIDTH+1 bits); o = (x[MSB] == ye[MSB]) & (s[MSB] != x[MSB]); z = ~|s.
- Flags are computed from the MSB digit and the full registered s at the end of RUN, not from any intermediate digit.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch x, ye and sub into operand shift registers, set carry=cin, clear digit counter, go to RUN.
  - RUN: each cycle add the low DIGIT bits of the x and ye shift registers plus carry. Shift the DIGIT-bit result into the partial-sum register from the top. Update carry. Increment counter. On the cycle the counter reaches WIDTH/DIGIT−1, load s, c, o, z and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE. Otherwise hold.
- s, c, o, z change only on the RUN→DONE transition and hold the last result through IDLE/RUN until the next completion.
- in_valid is ignored outside IDLE (no queuing). x, y and sub are sampled only on the accept edge and may change afterwards.
- DIGIT == WIDTH: one RUN cycle; behaves as a registered full adder.
- Reset (async, any state, including mid-RUN or DONE): state IDLE, counter 0, carry 0, operand/partial registers 0. Outputs go to s=0, c=0, o=0, z=0, out_valid=0, busy=0, in_ready=1. The in-flight operation is discarded.

## Timing
- Accept on the rising edge where in_valid & in_ready.
- out_valid rises exactly WIDTH/DIGIT cycles after the accept edge.
- The result is held stable while out_valid & ~out_ready, for any number of cycles.
- On the handshake edge out_valid falls and in_ready rises in the next cycle. Minimum initiation interval: WIDTH/DIGIT + 2 cycles (accept, RUN×N/D, DONE≥1).
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Counter width is clog2(WIDTH/DIGIT)+1. It never wraps within an operation.

## Test plan
WIDTH=8, DIGIT=2 unless noted; latency 4.
- add 0x7F+0x01, out_ready=1 -> out_valid 4 cycles after accept; s=0x80, c=0, o=1, z=0.
- add 0xFF+0x01 -> s=0x00, c=1, o=0, z=1. sub 0x05−0x05 -> s=0x00, c=1, o=0, z=1.
- sub 0x00−0x01 -> s=0xFF, c=0, o=0. sub 0x80−0x01 -> s=0x7F, c=1, o=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while pulsing in_valid with new operands -> s/flags/out_valid unchanged, in_ready=0, the pulse is not accepted. Raise out_ready -> IDLE next cycle, then a fresh op completes correctly.
- Async reset asserted mid-cycle in the 2nd RUN cycle -> immediately out_valid=0, busy=0, s=0, flags 0, in_ready=1. After release, 0x12+0x34 -> s=0x46, c=0, o=0, z=0.
- Sweep DIGIT ∈ {1,2,4,8} with 1000 random ops each against a reference model -> latency = 8/DIGIT and all of s, c, o, z match.
